vrased_reset_arbiter: RTL

- Sits directly downstream of the per-feature violation monitors (DMA/stack, key, atomicity, CASU update monitors).
- Each monitor drives a level "reset" request: high while it holds the system in KILL, low in RUN.
- This block merges those requests into the single registered system reset that feeds the MSP430 core reset input.
- Stretches every violation reset to a guaranteed minimum width and records which monitor(s) caused it, so post-boot trusted code can read the cause.

---
 rtl/vrased_pkg.sv | 18 +
 rtl/vrased_reset_arbiter_if.sv | 25 ++
 rtl/vrased_rst_cause_log.sv | 50 +++++
 rtl/vrased_reset_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/vrased_pkg.sv
// Shared definitions for the VRASED reset path: FSM state encoding, monitor RUN/KILL levels, default sizes.
package vrased_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    IDLE    = 2'd1,
    STRETCH = 2'd2,
    HOLD    = 2'd3
  } arb_state_t;

  localparam logic RUN  = 1'b0;
  localparam logic KILL = 1'b1;

  localparam int DEF_NSRC         = 4;
  localparam int DEF_PULSE_CYCLES = 8;
  localparam int DEF_CNT_W        = 8;

endpackage

// File: rtl/vrased_reset_arbiter_if.sv
// Monitor-side request bundle plus the merged reset and cause-log readback of the reset arbiter.
interface vrased_reset_arbiter_if
  import vrased_pkg::*;
#(
  parameter int NSRC  = DEF_NSRC,
  parameter int CNT_W = DEF_CNT_W
);
  logic [NSRC-1:0]  src_reset;
  logic             log_clr;
  logic             sys_reset;
  logic             armed;
  logic [NSRC-1:0]  first_cause;
  logic [NSRC-1:0]  cause_mask;
  logic [CNT_W-1:0] viol_count;

  modport master (
    output src_reset, log_clr,
    input  sys_reset, armed, first_cause, cause_mask, viol_count
  );

  modport slave (
    input  src_reset, log_clr,
    output sys_reset, armed, first_cause, cause_mask, viol_count
  );
endinterface

// File: rtl/vrased_rst_cause_log.sv
// Violation cause log: first-cause priority encoder, sticky source mask and saturating violation counter.
// All outputs registered; a logging event coinciding with log_clr wins over the clear.
module vrased_rst_cause_log
  import vrased_pkg::*;
#(
  parameter int NSRC  = DEF_NSRC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [NSRC-1:0]  src_reset,
  input  logic             log_evt,
  input  logic             mask_en,
  input  logic             log_clr,
  output logic [NSRC-1:0]  first_cause,
  output logic [NSRC-1:0]  cause_mask,
  output logic [CNT_W-1:0] viol_count
);

  logic [NSRC-1:0]  lowest_src;
  logic [NSRC-1:0]  mask_base;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_inc;

  // Two's-complement trick isolates the lowest set bit, i.e. the highest-priority monitor.
  assign lowest_src = src_reset & (~src_reset + 1'b1);

  assign mask_base = log_clr ? '0 : cause_mask;
  assign cnt_base  = log_clr ? '0 : viol_count;
  assign cnt_inc   = (&cnt_base) ? cnt_base : cnt_base + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_cause <= '0;
      cause_mask  <= '0;
      viol_count  <= '0;
    end else if (log_evt) begin
      first_cause <= lowest_src;
      cause_mask  <= mask_base | src_reset;
      viol_count  <= cnt_inc;
    end else if (log_clr) begin
      first_cause <= '0;
      cause_mask  <= '0;
      viol_count  <= '0;
    end else if (mask_en) begin
      cause_mask  <= cause_mask | src_reset;
    end
  end

endmodule

// File: rtl/vrased_reset_arbiter.sv
// Merges monitor KILL requests into one registered CPU reset, stretched to PULSE_CYCLES per violation (1-cycle latency).
// Define VRASED_RST_CAUSE_LOG_EN to build the cause log; otherwise first_cause/cause_mask/viol_count read 0.
module vrased_reset_arbiter
  import vrased_pkg::*;
#(
  parameter int NSRC         = DEF_NSRC,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vrased_reset_arbiter_if.slave bus
);

  localparam int            CW       = $clog2(PULSE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES - 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sys_q, sys_d;
  logic          armed_q, armed_d;
  logic          any_src;

  assign any_src = |bus.src_reset;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      sys_q   <= 1'b1;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sys_q   <= sys_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sys_d   = sys_q;
    armed_d = armed_q;
    case (state_q)
      BOOT: begin
        // Monitors power up in KILL; follow them until every one has released.
        sys_d = any_src;
        if (any_src == RUN) begin
          state_d = IDLE;
          armed_d = 1'b1;
        end
      end
      IDLE: begin
        sys_d = 1'b0;
        if (any_src == KILL) begin
          state_d = STRETCH;
          sys_d   = 1'b1;
          cnt_d   = CNT_LOAD;
        end
      end
      STRETCH: begin
        sys_d = 1'b1;
        if (cnt_q == '0) begin
          if (any_src == KILL) begin
            state_d = HOLD;
          end else begin
            state_d = IDLE;
            sys_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        sys_d = 1'b1;
        if (any_src == RUN) begin
          state_d = IDLE;
          sys_d   = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
        sys_d   = 1'b1;
      end
    endcase
  end

  assign bus.sys_reset = sys_q;
  assign bus.armed     = armed_q;

`ifdef VRASED_RST_CAUSE_LOG_EN
  logic log_evt;
  logic mask_en;

  assign log_evt = (state_q == IDLE) && (any_src == KILL);
  assign mask_en = (state_q != BOOT);

  vrased_rst_cause_log #(
    .NSRC  (NSRC),
    .CNT_W (CNT_W)
  ) u_cause_log (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_reset   (bus.src_reset),
    .log_evt     (log_evt),
    .mask_en     (mask_en),
    .log_clr     (bus.log_clr),
    .first_cause (bus.first_cause),
    .cause_mask  (bus.cause_mask),
    .viol_count  (bus.viol_count)
  );
`else
  logic unused_log_clr;
  assign unused_log_clr  = bus.log_clr;
  assign bus.first_cause = '0;
  assign bus.cause_mask  = '0;
  assign bus.viol_count  = '0;
`endif

endmodule
